// File: rtl/spi_master.sv
`timescale 1ns/1ps
// spi_master: controller-side driver for the 16-bit SPI link (CPOL = 0).
// On an accepted start it selects the slave and shifts one word out MSB-first.
// It captures the returned word on each SCK falling edge and publishes it
// when the frame closes. SCK is divided down from clk_100 so that the slave's
// 2-flop SCK edge detector can follow it.
module spi_master #(
  parameter int HALF_DIV = 10,  // SCK half-period in clk_100 cycles (min 6)
  parameter int LEAD     = 10,  // SPISTE fall to first SCK rise (min 2)
  parameter int GAP      = 10   // minimum SPISTE-high cycles between frames (min 2)
) (
  input  logic        clk_100,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] txd_data,
  output logic        busy,
  output logic        SPISTE,
  output logic        SCK,
  output logic        SPISIMO,
  input  logic        SPISOMI,
  output logic [15:0] rxd_data,
  output logic        rxd_flag
);

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;

  // Phase counter reload values: a phase of N cycles loads N-1 and ends at zero.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(LEAD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HIGH,
    ST_LOW,
    ST_TAIL,
    ST_GAP
  } state_t;

  state_t                 state_reg;
  logic [CNT_W-1:0]       phase_cnt_reg;
  logic [3:0]             bit_cnt_reg;
  logic [15:0]            tx_sr_reg;
  logic [15:0]            rx_sr_reg;
  logic [SYNC_STAGES-1:0] somi_sync_reg;

  logic phase_done;
  logic somi_sync;

  assign phase_done = (phase_cnt_reg == '0);
  assign somi_sync  = somi_sync_reg[SYNC_STAGES-1];

  // SPISOMI is asynchronous to clk_100, so it is passed through a flop chain
  // before the shift register samples it.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_somi_sync
      if (gi == 0) begin : g_first
        // First synchronizer stage samples the raw pin.
        always_ff @(posedge clk_100 or posedge RST) begin
          if (RST) begin
            somi_sync_reg[gi] <= 1'b0;
          end else begin
            somi_sync_reg[gi] <= SPISOMI;
          end
        end
      end else begin : g_next
        // Later stages resolve metastability from the previous stage.
        always_ff @(posedge clk_100 or posedge RST) begin
          if (RST) begin
            somi_sync_reg[gi] <= 1'b0;
          end else begin
            somi_sync_reg[gi] <= somi_sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Frame sequencer: every output is registered so the pins are glitch-free.
  always_ff @(posedge clk_100 or posedge RST) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      phase_cnt_reg <= '0;
      bit_cnt_reg   <= 4'd0;
      tx_sr_reg     <= 16'h0000;
      rx_sr_reg     <= 16'h0000;
      busy          <= 1'b0;
      SPISTE        <= 1'b1;
      SCK           <= 1'b0;
      SPISIMO       <= 1'b0;
      rxd_data      <= 16'h0000;
      rxd_flag      <= 1'b0;
    end else begin
      rxd_flag <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // start is only looked at here, so requests during a frame are dropped.
          if (start) begin
            tx_sr_reg     <= txd_data;
            rx_sr_reg     <= 16'h0000;
            SPISTE        <= 1'b0;
            SPISIMO       <= txd_data[15];
            bit_cnt_reg   <= 4'd0;
            phase_cnt_reg <= LEAD_LOAD;
            busy          <= 1'b1;
            state_reg     <= ST_LEAD;
          end
        end

        ST_LEAD: begin
          if (phase_done) begin
            SCK           <= 1'b1;
            phase_cnt_reg <= HALF_LOAD;
            state_reg     <= ST_HIGH;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - CNT_W'(1);
          end
        end

        ST_HIGH: begin
          // The falling edge samples the bit the slave put out after the rise,
          // and launches the next MOSI bit so it is settled for the next rise.
          if (phase_done) begin
            SCK           <= 1'b0;
            rx_sr_reg     <= {rx_sr_reg[14:0], somi_sync};
            phase_cnt_reg <= HALF_LOAD;
            if (bit_cnt_reg == 4'd15) begin
              state_reg <= ST_TAIL;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              tx_sr_reg   <= {tx_sr_reg[14:0], 1'b0};
              SPISIMO     <= tx_sr_reg[14];
              state_reg   <= ST_LOW;
            end
          end else begin
            phase_cnt_reg <= phase_cnt_reg - CNT_W'(1);
          end
        end

        ST_LOW: begin
          if (phase_done) begin
            SCK           <= 1'b1;
            phase_cnt_reg <= HALF_LOAD;
            state_reg     <= ST_HIGH;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - CNT_W'(1);
          end
        end

        ST_TAIL: begin
          // Hold SCK low for a full half-period before releasing the slave.
          if (phase_done) begin
            SPISTE        <= 1'b1;
            rxd_data      <= rx_sr_reg;
            rxd_flag      <= 1'b1;
            phase_cnt_reg <= GAP_LOAD;
            state_reg     <= ST_GAP;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - CNT_W'(1);
          end
        end

        ST_GAP: begin
          // SPISTE high long enough for the slave to reset its bit counters.
          if (phase_done) begin
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            phase_cnt_reg <= phase_cnt_reg - CNT_W'(1);
          end
        end

        default: begin
          busy      <= 1'b0;
          SPISTE    <= 1'b1;
          SCK       <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
// tb_spi_master: two masters (default timing and minimum timing) each talk to
// a behavioural slave. Stimulus pushes expected frames into a queue; a
// per-instance monitor checks each completed frame against it.
module tb_spi_master;

  typedef struct {
    logic [15:0] tx;
    logic [15:0] reply;
  } frame_t;

  logic clk_100 = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       start_v;
  logic [15:0]      txd_a   [2];
  logic [15:0]      reply_a [2];
  logic [1:0]       busy_v, ste_v, sck_v, simo_v, flag_v;
  logic [1:0][15:0] rxd_v;
  bit               abort_pending = 1'b0;

  frame_t exp_q0 [$];
  frame_t exp_q1 [$];

  int errors = 0;
  int checks = 0;

  always #5 clk_100 = ~clk_100;

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d: got 0x%0h, required 0x%0h at %0t", name, inst, act, req, $time);
    end
  endtask

  function automatic int exp_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic exp_push(input int i, input frame_t f);
    if (i == 0) exp_q0.push_back(f);
    else        exp_q1.push_back(f);
  endtask

  task automatic exp_pop(input int i, output frame_t f);
    if (i == 0) f = exp_q0.pop_front();
    else        f = exp_q1.pop_front();
  endtask

  // ---------------------------------------------------------------- instances
  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int HD = (gi == 0) ? 10 : 6;
    localparam int LD = (gi == 0) ? 10 : 2;
    localparam int GP = (gi == 0) ? 10 : 2;

    logic        ste, sck, simo, busy, flag;
    logic        somi = 1'b0;
    logic [15:0] rxd;

    spi_master #(.HALF_DIV(HD), .LEAD(LD), .GAP(GP)) u_dut (
      .clk_100  (clk_100),
      .RST      (rst),
      .start    (start_v[gi]),
      .txd_data (txd_a[gi]),
      .busy     (busy),
      .SPISTE   (ste),
      .SCK      (sck),
      .SPISIMO  (simo),
      .SPISOMI  (somi),
      .rxd_data (rxd),
      .rxd_flag (flag)
    );

    assign busy_v[gi] = busy;
    assign ste_v[gi]  = ste;
    assign sck_v[gi]  = sck;
    assign simo_v[gi] = simo;
    assign flag_v[gi] = flag;
    assign rxd_v[gi]  = rxd;

    // Behavioural slave: 2-flop SCK edge detect; on each detected rise it
    // samples MOSI and presents its next reply bit, MSB first.
    logic        sck_d1 = 1'b0, sck_d2 = 1'b0;
    logic [15:0] s_tx = 16'h0000, s_rx = 16'h0000;
    always @(posedge clk_100) begin
      sck_d1 <= sck;
      sck_d2 <= sck_d1;
      if (ste) begin
        s_tx <= reply_a[gi];
      end else if (sck_d1 && !sck_d2) begin
        s_rx <= {s_rx[14:0], simo};
        somi <= s_tx[15];
        s_tx <= {s_tx[14:0], 1'b0};
      end
    end

    // Monitor: measures each frame on the pins and scores it at SPISTE rise.
    initial begin : mon
      int low_cnt, high_cnt, busy_cnt, rises, run_len;
      bit had_frame, phase_bad, simo_bad, fell, ended;
      logic p_ste, p_sck, p_busy, p_simo;
      frame_t e;
      low_cnt = 0; high_cnt = 0; busy_cnt = 0; rises = 0; run_len = 0;
      had_frame = 0; phase_bad = 0; simo_bad = 0;
      p_ste = 1'b1; p_sck = 1'b0; p_busy = 1'b0; p_simo = 1'b0;
      forever begin
        @(negedge clk_100);
        fell  = !ste && p_ste;
        ended = ste && !p_ste;
        if (flag && (!ended || abort_pending)) begin
          checks++; errors++;
          $display("FAIL rxd_flag_spurious inst%0d: got 1, required 0 at %0t", gi, $time);
        end
        if (busy) begin
          busy_cnt++;
        end else if (p_busy) begin
          if (!abort_pending) check("busy_len", gi, busy_cnt, LD + 32*HD + GP);
          busy_cnt = 0;
        end
        if (fell) begin
          check("busy_rise_with_ste", gi, {p_busy, busy}, 2'b01);
          if (had_frame) begin
            checks++;
            if (high_cnt < GP + 1) begin
              errors++;
              $display("FAIL ste_gap inst%0d: got %0d high cycles, required >= %0d", gi, high_cnt, GP + 1);
            end
          end
          low_cnt = 1; rises = 0; run_len = 1; phase_bad = 0; simo_bad = 0;
        end else if (!ste) begin
          low_cnt++;
          if (sck != p_sck) begin
            if (rises == 0 && sck) begin
              if (run_len != LD) phase_bad = 1;
            end else if (run_len != HD) begin
              phase_bad = 1;
            end
            if (sck) rises++;
            run_len = 1;
          end else begin
            run_len++;
          end
          if (simo != p_simo && !(p_sck && !sck)) simo_bad = 1;
        end else if (ended) begin
          if (abort_pending) begin
            had_frame = 0;
          end else begin
            if (run_len != HD) phase_bad = 1;
            if (exp_size(gi) == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_frame inst%0d: got a frame, required none at %0t", gi, $time);
            end else begin
              exp_pop(gi, e);
              check("ste_low_len", gi, low_cnt, LD + 32*HD);
              check("sck_rises",   gi, rises, 16);
              check("sck_phases",  gi, phase_bad, 0);
              check("simo_stable", gi, simo_bad, 0);
              check("slave_rx",    gi, s_rx, e.tx);
              check("rxd_flag",    gi, flag, 1);
              check("rxd_data",    gi, rxd, e.reply);
              $display("frame inst%0d tx=0x%04h slave_got=0x%04h reply=0x%04h rxd=0x%04h", gi, e.tx, s_rx, e.reply, rxd);
            end
            had_frame = 1;
          end
          high_cnt = 1;
        end else begin
          high_cnt++;
        end
        p_ste = ste; p_sck = sck; p_busy = busy; p_simo = simo;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  function automatic logic sig(input int i, input int sel);
    return (sel == 0) ? busy_v[i] : ste_v[i];
  endfunction

  task automatic wait_for(input int i, input int sel, input logic lvl, input int budget, input string what);
    int n;
    n = 0;
    while (sig(i, sel) !== lvl && n < budget) begin
      @(negedge clk_100);
      n++;
    end
    if (sig(i, sel) !== lvl) begin
      checks++; errors++;
      $display("FAIL timeout_%s inst%0d: got %0b after %0d cycles, required %0b", what, i, sig(i, sel), budget, lvl);
    end
  endtask

  task automatic wait_rises(input int i, input int n, input int budget);
    int seen, cyc;
    logic p;
    seen = 0; cyc = 0; p = sck_v[i];
    while (seen < n && cyc < budget) begin
      @(negedge clk_100);
      cyc++;
      if (sck_v[i] && !p) seen++;
      p = sck_v[i];
    end
    if (seen < n) begin
      checks++; errors++;
      $display("FAIL timeout_sck_rises inst%0d: got %0d rises, required %0d", i, seen, n);
    end
  endtask

  task automatic send(input int i, input logic [15:0] tx_w, input logic [15:0] rep_w, input bit expect_frame);
    wait_for(i, 0, 1'b0, 1000, "idle");
    txd_a[i]   = tx_w;
    reply_a[i] = rep_w;
    if (expect_frame) exp_push(i, '{tx: tx_w, reply: rep_w});
    start_v[i] = 1'b1;
    @(negedge clk_100);
    start_v[i] = 1'b0;
    txd_a[i]   = 16'($urandom);
    check("busy_after_start", i, busy_v[i], 1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    logic [15:0] words [3];
    int          inst;
    logic [15:0] t, r;
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF;
    start_v = 2'b00;
    txd_a[0] = 16'h0000; txd_a[1] = 16'h0000;
    reply_a[0] = 16'h0000; reply_a[1] = 16'h0000;
    rst = 1'b1;
    repeat (4) @(negedge clk_100);
    for (int i = 0; i < 2; i++) begin
      check("reset_ste",  i, ste_v[i], 1);
      check("reset_sck",  i, sck_v[i], 0);
      check("reset_simo", i, simo_v[i], 0);
      check("reset_busy", i, busy_v[i], 0);
      check("reset_flag", i, flag_v[i], 0);
      check("reset_rxd",  i, rxd_v[i], 16'h0000);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk_100);

    // Single frame with the reference words.
    send(0, 16'hA5C3, 16'h3C5A, 1);
    wait_for(0, 0, 1'b0, 500, "frame1_done");

    // Start pulses at bit 4 and during the gap must be ignored.
    send(0, 16'h6E1B, 16'h91D4, 1);
    wait_rises(0, 4, 200);
    start_v[0] = 1'b1; @(negedge clk_100); start_v[0] = 1'b0;
    wait_for(0, 1, 1'b1, 400, "ste_release");
    repeat (3) @(negedge clk_100);
    start_v[0] = 1'b1; @(negedge clk_100); start_v[0] = 1'b0;
    wait_for(0, 0, 1'b0, 50, "ignore_done");
    repeat (30) @(negedge clk_100);
    check("no_extra_frame_ste",  0, ste_v[0], 1);
    check("no_extra_frame_busy", 0, busy_v[0], 0);

    // start held high for three back-to-back frames; txd_data wobbles mid-frame.
    wait_for(0, 0, 1'b0, 500, "idle_before_held");
    txd_a[0] = words[0]; reply_a[0] = ~words[0];
    exp_push(0, '{tx: words[0], reply: ~words[0]});
    start_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_for(0, 0, 1'b1, 50, "held_accept");
      if (k < 2) begin
        reply_a[0] = ~words[k+1];
        exp_push(0, '{tx: words[k+1], reply: ~words[k+1]});
        txd_a[0] = 16'($urandom);
        repeat (100) @(negedge clk_100);
        txd_a[0] = words[k+1];
      end else begin
        start_v[0] = 1'b0;
        txd_a[0] = 16'($urandom);
      end
      wait_for(0, 0, 1'b0, 500, "held_done");
    end

    // Reset after the 7th SCK rise aborts the frame.
    send(0, 16'($urandom), 16'($urandom), 0);
    wait_rises(0, 7, 300);
    abort_pending = 1'b1;
    rst = 1'b1;
    #1;
    check("abort_ste",  0, ste_v[0], 1);
    check("abort_sck",  0, sck_v[0], 0);
    check("abort_simo", 0, simo_v[0], 0);
    check("abort_busy", 0, busy_v[0], 0);
    check("abort_flag", 0, flag_v[0], 0);
    check("abort_rxd",  0, rxd_v[0], 16'h0000);
    repeat (5) @(negedge clk_100);
    rst = 1'b0;
    repeat (20) @(negedge clk_100);
    check("abort_rxd_held", 0, rxd_v[0], 16'h0000);
    abort_pending = 1'b0;
    send(0, 16'h1234, 16'hBEEF, 1);
    wait_for(0, 0, 1'b0, 500, "post_abort_done");

    // Minimum timing instance.
    send(1, 16'hFFFF, 16'h0000, 1);
    wait_for(1, 0, 1'b0, 300, "min_frame1");
    send(1, 16'h5555, 16'hAAAA, 1);
    wait_for(1, 0, 1'b0, 300, "min_frame2");

    // Randomised frames, alternating instances, with stray starts while busy.
    for (int n = 0; n < 16; n++) begin
      inst = n % 2;
      t = 16'($urandom);
      r = 16'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk_100);
      send(inst, t, r, 1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(2, (inst == 0) ? 330 : 190)) @(negedge clk_100);
        if (busy_v[inst]) begin
          start_v[inst] = 1'b1; @(negedge clk_100); start_v[inst] = 1'b0;
        end
      end
      wait_for(inst, 0, 1'b0, 1000, "rand_done");
    end

    repeat (30) @(negedge clk_100);
    check("exp_queue_empty", 0, exp_size(0), 0);
    check("exp_queue_empty", 1, exp_size(1), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
